// File: rtl/adrv9001_tx_framer.sv
// Transmit framer for one ADRV9001 LVDS SSI channel: splits 16-bit I/Q samples
// into high/low byte words per lane with a strobe pulse on each sample's MSB.
module adrv9001_tx_framer #(
    parameter bit SWAP_DIFF = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] s_i,
    input  logic [15:0] s_q,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  tx_i,
    output logic [7:0]  tx_q,
    output logic [7:0]  tx_strb,
    output logic        busy,
    output logic [15:0] underflow_cnt,
    input  logic        underflow_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2
    } state_t;

    localparam logic [7:0] INV = {8{SWAP_DIFF}};

    state_t      state_q, state_d;
    logic [15:0] hold_i_q, hold_i_d;
    logic [15:0] hold_q_q, hold_q_d;
    logic        hold_valid_q, hold_valid_d;
    logic [15:0] sh_i_q, sh_i_d;
    logic [15:0] sh_q_q, sh_q_d;
    logic [15:0] underflow_cnt_q, underflow_cnt_d;
    logic        load;
    logic        underflow;
    logic        accept;

    assign s_ready = enable & ~hold_valid_q & ~rst;
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d         = state_q;
        hold_i_d        = hold_i_q;
        hold_q_d        = hold_q_q;
        hold_valid_d    = hold_valid_q;
        sh_i_d          = sh_i_q;
        sh_q_d          = sh_q_q;
        underflow_cnt_d = underflow_cnt_q;
        load            = 1'b0;
        underflow       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && hold_valid_q) begin
                    load    = 1'b1;
                    state_d = HI;
                end
            end
            HI: state_d = LO;
            LO: begin
                if (enable && hold_valid_q) begin
                    load    = 1'b1;
                    state_d = HI;
                end else begin
                    underflow = enable;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // accept and load are exclusive: accept needs an empty hold, load a full one
        if (accept) begin
            hold_i_d     = s_i;
            hold_q_d     = s_q;
            hold_valid_d = 1'b1;
        end
        if (load) begin
            sh_i_d       = hold_i_q;
            sh_q_d       = hold_q_q;
            hold_valid_d = 1'b0;
        end

        if (underflow_clr) begin
            underflow_cnt_d = 16'h0000;
        end else if (underflow && (underflow_cnt_q != 16'hFFFF)) begin
            underflow_cnt_d = underflow_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            hold_i_q        <= 16'h0000;
            hold_q_q        <= 16'h0000;
            hold_valid_q    <= 1'b0;
            sh_i_q          <= 16'h0000;
            sh_q_q          <= 16'h0000;
            underflow_cnt_q <= 16'h0000;
        end else begin
            state_q         <= state_d;
            hold_i_q        <= hold_i_d;
            hold_q_q        <= hold_q_d;
            hold_valid_q    <= hold_valid_d;
            sh_i_q          <= sh_i_d;
            sh_q_q          <= sh_q_d;
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    // Lane words decode straight from state so async reset shows idle fill at once
    always_comb begin
        tx_i    = INV;
        tx_q    = INV;
        tx_strb = INV;
        case (state_q)
            HI: begin
                tx_i    = sh_i_q[15:8] ^ INV;
                tx_q    = sh_q_q[15:8] ^ INV;
                tx_strb = 8'h80 ^ INV;
            end
            LO: begin
                tx_i    = sh_i_q[7:0] ^ INV;
                tx_q    = sh_q_q[7:0] ^ INV;
                tx_strb = 8'h00 ^ INV;
            end
            default: ;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign underflow_cnt = underflow_cnt_q;

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
// Scoreboard bench for adrv9001_tx_framer: one instance per SWAP_DIFF setting
// share the same stimulus; a negedge monitor checks every lane word.
module tb_adrv9001_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] s_i = 16'h0000;
    logic [15:0] s_q = 16'h0000;
    logic        s_valid = 1'b0;
    logic        underflow_clr = 1'b0;

    logic        s_ready0, s_ready1, busy0, busy1;
    logic [7:0]  tx_i0, tx_q0, tx_strb0, tx_i1, tx_q1, tx_strb1;
    logic [15:0] cnt0, cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int run_len = 0;
    int last_run = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    adrv9001_tx_framer #(.SWAP_DIFF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .s_i(s_i), .s_q(s_q),
        .s_valid(s_valid), .s_ready(s_ready0), .tx_i(tx_i0), .tx_q(tx_q0),
        .tx_strb(tx_strb0), .busy(busy0), .underflow_cnt(cnt0),
        .underflow_clr(underflow_clr));

    adrv9001_tx_framer #(.SWAP_DIFF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .s_i(s_i), .s_q(s_q),
        .s_valid(s_valid), .s_ready(s_ready1), .tx_i(tx_i1), .tx_q(tx_q1),
        .tx_strb(tx_strb1), .busy(busy1), .underflow_cnt(cnt1),
        .underflow_clr(underflow_clr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected word per busy cycle, checks idle fill otherwise
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst) begin
            run_len = 0;
        end else if (busy0) begin
            run_len++;
            chk("busy_match", {31'd0, busy1}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {8'd0, tx_i0, tx_q0, tx_strb0}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("word_swap0", {8'd0, tx_i0, tx_q0, tx_strb0}, {8'd0, e});
                chk("word_swap1", {8'd0, tx_i1, tx_q1, tx_strb1}, {8'd0, e ^ 24'hFFFFFF});
            end
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
            chk("idle_fill0", {8'd0, tx_i0, tx_q0, tx_strb0}, 32'h0000_0000);
            chk("idle_fill1", {8'd0, tx_i1, tx_q1, tx_strb1}, 32'h00FF_FFFF);
        end
    end

    task automatic send(input logic [15:0] i, input logic [15:0] q);
        bit done = 1'b0;
        s_i = i;
        s_q = q;
        s_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (s_ready0) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            chk("send_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({i[15:8], q[15:8], 8'h80});
            exp_q.push_back({i[7:0], q[7:0], 8'h00});
        end
        s_valid = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bump_exp();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_0"}, {16'd0, cnt0}, {16'd0, exp_cnt});
        chk({name, "_1"}, {16'd0, cnt1}, {16'd0, exp_cnt});
    endtask

    initial begin
        enable = 1'b1;
        edges(3);
        chk("rst_tx0", {8'd0, tx_i0, tx_q0, tx_strb0}, 32'h0000_0000);
        chk("rst_tx1", {8'd0, tx_i1, tx_q1, tx_strb1}, 32'h00FF_FFFF);
        chk("rst_ready", {30'd0, s_ready0, s_ready1}, 32'd0);
        chk("rst_busy", {30'd0, busy0, busy1}, 32'd0);
        chk_cnt("rst_cnt");
        rst = 1'b0;
        edges(2);

        // single sample, then underflow
        send(16'h1234, 16'hABCD);
        edges(4);
        bump_exp();
        chk_cnt("single_cnt");

        // continuous stream of 8
        underflow_clr = 1'b1;
        edges(1);
        underflow_clr = 1'b0;
        exp_cnt = 16'h0000;
        for (int n = 0; n < 8; n++) begin
            send(16'h1111 * 16'(n + 1), 16'hF0F0 ^ 16'(n * 16'h0123));
            chk_cnt("stream_cnt");
        end
        edges(4);
        chk("stream_run", last_run, 32'd16);
        bump_exp();
        chk_cnt("stream_end_cnt");

        // enable drop during HI: LO still emitted, no count
        send(16'h5A5A, 16'hC33C);
        edges(1);
        enable = 1'b0;
        edges(4);
        chk_cnt("drop_cnt");
        // held sample retained while disabled
        enable = 1'b1;
        send(16'h8001, 16'h7FFE);
        enable = 1'b0;
        edges(3);
        chk("held_busy_off", {31'd0, busy0}, 32'd0);
        enable = 1'b1;
        edges(1);
        chk("held_busy_on", {31'd0, busy0}, 32'd1);
        edges(3);
        bump_exp();
        chk_cnt("held_cnt");

        // clear wins over same-cycle underflow
        send(16'h0F0F, 16'hF00F);
        edges(2);
        underflow_clr = 1'b1;
        edges(1);
        underflow_clr = 1'b0;
        exp_cnt = 16'h0000;
        chk_cnt("clr_prio_cnt");

        // saturation near the top of the counter
        force dut0.underflow_cnt_q = 16'hFFFE;
        force dut1.underflow_cnt_q = 16'hFFFE;
        #1;
        release dut0.underflow_cnt_q;
        release dut1.underflow_cnt_q;
        exp_cnt = 16'hFFFE;
        send(16'h0001, 16'h0002);
        edges(4);
        bump_exp();
        chk_cnt("sat_cnt_a");
        send(16'h0003, 16'h0004);
        edges(4);
        bump_exp();
        chk_cnt("sat_cnt_b");

        // async reset during LO with a held sample
        send(16'hDEAD, 16'hBEEF);
        send(16'hCAFE, 16'hF00D);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_cnt = 16'h0000;
        chk("amid_tx0", {8'd0, tx_i0, tx_q0, tx_strb0}, 32'h0000_0000);
        chk("amid_tx1", {8'd0, tx_i1, tx_q1, tx_strb1}, 32'h00FF_FFFF);
        chk("amid_ready", {30'd0, s_ready0, s_ready1}, 32'd0);
        edges(2);
        rst = 1'b0;
        edges(6);
        chk("post_rst_busy", {30'd0, busy0, busy1}, 32'd0);
        chk_cnt("post_rst_cnt");
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
